// File: rtl/key_bounce_gen.sv
`default_nettype none
// ============================================================================
// Module      : key_bounce_gen
// Description : Emulates a bouncing active-low push button: press burst, hold,
//               release burst. Define KEY_BOUNCE_GEN_LFSR_EN for LFSR-randomised
//               glitch phase widths; otherwise every phase is GLITCH_FIX wide.
// Revision    : 1.0 - initial release
// ============================================================================
module key_bounce_gen #(
    parameter int          BOUNCE_CNT = 3,
    parameter int          GLITCH_FIX = 4,
    parameter int          GLITCH_W   = 3,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        press_req,
    input  logic [15:0] hold_len,
    input  logic        abort,
    output logic        key_out,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BNC_DN = 2'd1;
    localparam logic [1:0] c_HOLD   = 2'd2;
    localparam logic [1:0] c_BNC_UP = 2'd3;

    localparam int              c_NPH  = 2 * BOUNCE_CNT;
    localparam int              c_IW   = (c_NPH > 1) ? $clog2(c_NPH) : 1;
    localparam logic [c_IW-1:0] c_LAST = c_IW'((BOUNCE_CNT > 0) ? c_NPH - 1 : 0);
`ifdef KEY_BOUNCE_GEN_LFSR_EN
    localparam int              c_PW   = GLITCH_W + 1;
`else
    localparam int              c_PW   = $clog2(GLITCH_FIX + 1);
`endif

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_IW-1:0] r_idx;
    logic [c_IW-1:0] w_idx_nxt;
    logic [c_PW-1:0] r_phase_cnt;
    logic [c_PW-1:0] w_width_m1;
    logic [15:0]     r_hold_cnt;
    logic [15:0]     r_hold_len;
    logic [15:0]     w_hold_src;
    logic [15:0]     w_hold_load;
    logic            w_phase_end;
    logic            w_burst_last;
    logic            w_in_burst;
    logic            w_enter_burst;
    logic            w_next_phase;
    logic            w_phase_start;
    logic            r_key;
    logic            r_busy;
    logic            r_done;
    logic            w_key_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;

    assign w_phase_end  = (r_phase_cnt == '0);
    assign w_burst_last = w_phase_end && (r_idx == c_LAST);
    assign w_in_burst   = (r_state == c_BNC_DN) || (r_state == c_BNC_UP);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a request on the done cycle is deliberately dropped
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (press_req && !r_done) begin
                        w_state_nxt = (BOUNCE_CNT > 0) ? c_BNC_DN : c_HOLD;
                    end
                end
                c_BNC_DN: begin
                    if (w_burst_last) begin
                        w_state_nxt = c_HOLD;
                    end
                end
                c_HOLD: begin
                    if (r_hold_cnt == 16'd0) begin
                        w_state_nxt = (BOUNCE_CNT > 0) ? c_BNC_UP : c_IDLE;
                    end
                end
                c_BNC_UP: begin
                    if (w_burst_last) begin
                        w_state_nxt = c_IDLE;
                    end
                end
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    // Phase sequencing inside a burst
    always_comb begin
        w_enter_burst = ((w_state_nxt == c_BNC_DN) && (r_state != c_BNC_DN)) ||
                        ((w_state_nxt == c_BNC_UP) && (r_state != c_BNC_UP));
        w_next_phase  = w_in_burst && (w_state_nxt == r_state) && w_phase_end;
        w_phase_start = w_enter_burst || w_next_phase;
        w_idx_nxt     = r_idx;
        if (w_enter_burst) begin
            w_idx_nxt = '0;
        end else if (w_next_phase) begin
            w_idx_nxt = r_idx + 1'b1;
        end
    end

    // Output logic: the press burst settles low on its final phase
    always_comb begin
        w_key_nxt  = 1'b1;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            c_IDLE: begin
                w_done_nxt = (r_state != c_IDLE) && !abort;
            end
            c_BNC_DN: begin
                w_busy_nxt = 1'b1;
                w_key_nxt  = w_idx_nxt[0] && (w_idx_nxt != c_LAST);
            end
            c_HOLD: begin
                w_busy_nxt = 1'b1;
                w_key_nxt  = 1'b0;
            end
            c_BNC_UP: begin
                w_busy_nxt = 1'b1;
                w_key_nxt  = ~w_idx_nxt[0];
            end
            default: begin
                w_key_nxt  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key  <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_key  <= w_key_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Without bursts HOLD is entered straight from IDLE, before hold_len is latched
    assign w_hold_src  = (r_state == c_IDLE) ? hold_len : r_hold_len;
    assign w_hold_load = (w_hold_src == 16'd0) ? 16'd0 : w_hold_src - 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_phase_cnt <= '0;
            r_hold_cnt  <= 16'd0;
            r_hold_len  <= 16'd0;
        end else begin
            r_idx <= w_idx_nxt;
            if (w_phase_start) begin
                r_phase_cnt <= w_width_m1;
            end else if (!w_phase_end) begin
                r_phase_cnt <= r_phase_cnt - 1'b1;
            end
            if ((r_state == c_IDLE) && (w_state_nxt != c_IDLE)) begin
                r_hold_len <= hold_len;
            end
            if ((w_state_nxt == c_HOLD) && (r_state != c_HOLD)) begin
                r_hold_cnt <= w_hold_load;
            end else if (r_hold_cnt != 16'd0) begin
                r_hold_cnt <= r_hold_cnt - 16'd1;
            end
        end
    end

`ifdef KEY_BOUNCE_GEN_LFSR_EN
    localparam logic [15:0] c_SEED = (SEED == 16'd0) ? 16'hACE1 : SEED;

    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    // Fibonacci taps 16,14,13,11; width uses the value current at phase start
    assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_width_m1 = c_PW'(r_lfsr[GLITCH_W-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= c_SEED;
        end else if (w_phase_start) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end
`else
    assign w_width_m1 = c_PW'(GLITCH_FIX - 1);
`endif

    assign key_out = r_key;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_key_bounce_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_bounce_gen
// Description : Directed self-checking bench for key_bounce_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_bounce_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        press_req;
    logic [15:0] hold_len;
    logic        abort;
    logic        key_out;
    logic        busy;
    logic        done;

    logic        press0;
    logic [15:0] hold0;
    logic        abort0;
    logic        key0;
    logic        busy0;
    logic        done0;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    key_bounce_gen #(
        .BOUNCE_CNT (2),
        .GLITCH_FIX (3),
        .GLITCH_W   (3),
        .SEED       (16'hACE1)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .press_req (press_req),
        .hold_len  (hold_len),
        .abort     (abort),
        .key_out   (key_out),
        .busy      (busy),
        .done      (done)
    );

    key_bounce_gen #(
        .BOUNCE_CNT (0),
        .GLITCH_FIX (3),
        .GLITCH_W   (3),
        .SEED       (16'hACE1)
    ) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .press_req (press0),
        .hold_len  (hold0),
        .abort     (abort0),
        .key_out   (key0),
        .busy      (busy0),
        .done      (done0)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    // Expected {key_out, busy, done} in cycle N+k for BOUNCE_CNT=2, width 3, hold 10
    function automatic logic [2:0] exp_vec(input int k);
        logic lo;
        lo = (k >= 1 && k <= 3) || (k >= 7 && k <= 22) ||
             (k >= 26 && k <= 28) || (k >= 32 && k <= 34);
        return {~lo, (k >= 1 && k <= 34), (k == 35)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; press_req = 1'b0; abort = 1'b0; hold_len = 16'd0;
        press0 = 1'b0; abort0 = 1'b0; hold0 = 16'd0;
        tick(); tick();
        n_checks++;
        if ({key_out, busy, done} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset_main: got %b want 100", {key_out, busy, done});
        end
        n_checks++;
        if ({key0, busy0, done0} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset_nobounce: got %b want 100", {key0, busy0, done0});
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({key_out, busy, done} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset_release: got %b want 100", {key_out, busy, done});
        end
    endtask

    task automatic test_waveform();
        hold_len = 16'd10; press_req = 1'b1;
        tick();
        press_req = 1'b0; hold_len = 16'd99;
        for (int k = 1; k <= 36; k++) begin
            n_checks++;
            if ({key_out, busy, done} !== exp_vec(k)) begin
                n_errors++;
                $display("FAIL waveform k=%0d: key/busy/done got %b want %b",
                         k, {key_out, busy, done}, exp_vec(k));
            end
            if (k < 36) tick();
        end
    endtask

    task automatic test_zero_hold();
        hold0 = 16'd0; press0 = 1'b1;
        tick();
        press0 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if ({key0, busy0, done0} !== {(k != 1), (k == 1), (k == 2)}) begin
                n_errors++;
                $display("FAIL zero_hold k=%0d: got %b want %b", k,
                         {key0, busy0, done0}, {(k != 1), (k == 1), (k == 2)});
            end
            tick();
        end
        hold0 = 16'd5; press0 = 1'b1;
        tick();
        press0 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            n_checks++;
            if ({key0, busy0, done0} !== {(k > 5), (k <= 5), (k == 6)}) begin
                n_errors++;
                $display("FAIL hold5_nobounce k=%0d: got %b want %b", k,
                         {key0, busy0, done0}, {(k > 5), (k <= 5), (k == 6)});
            end
            tick();
        end
    endtask

    task automatic test_repress();
        int dones;
        dones = 0;
        hold_len = 16'd10; press_req = 1'b1;
        tick();
        press_req = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            n_checks++;
            if ({key_out, busy, done} !== exp_vec(k)) begin
                n_errors++;
                $display("FAIL repress k=%0d: got %b want %b", k,
                         {key_out, busy, done}, exp_vec(k));
            end
            if (done === 1'b1) dones++;
            press_req = (k == 5) || (k == 20) || (k == 35) || (k == 36);
            tick();
        end
        press_req = 1'b0;
        n_checks++;
        if (dones != 1) begin
            n_errors++;
            $display("FAIL repress_done_count: got %0d want 1", dones);
        end
        n_checks++;
        if ({key_out, busy, done} !== 3'b010) begin
            n_errors++;
            $display("FAIL press_after_done: got %b want 010", {key_out, busy, done});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if ({key_out, busy, done} !== 3'b100) begin
            n_errors++;
            $display("FAIL abort_in_burst: got %b want 100", {key_out, busy, done});
        end
        tick();
    endtask

    task automatic test_abort();
        hold_len = 16'd10; press_req = 1'b1;
        tick();
        press_req = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            n_checks++;
            if ({key_out, busy, done} !== exp_vec(k)) begin
                n_errors++;
                $display("FAIL abort_pre k=%0d: got %b want %b", k,
                         {key_out, busy, done}, exp_vec(k));
            end
            abort = (k == 15);
            tick();
        end
        abort = 1'b0;
        for (int k = 16; k <= 17; k++) begin
            n_checks++;
            if ({key_out, busy, done} !== 3'b100) begin
                n_errors++;
                $display("FAIL abort_post k=%0d: got %b want 100", k, {key_out, busy, done});
            end
            press_req = (k == 17);
            tick();
        end
        press_req = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            n_checks++;
            if ({key_out, busy, done} !== exp_vec(k)) begin
                n_errors++;
                $display("FAIL abort_restart k=%0d: got %b want %b", k,
                         {key_out, busy, done}, exp_vec(k));
            end
            tick();
        end
        abort = 1'b1; press_req = 1'b1;
        tick();
        abort = 1'b0; press_req = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            n_checks++;
            if ({key_out, busy, done} !== 3'b100) begin
                n_errors++;
                $display("FAIL abort_with_press k=%0d: got %b want 100", k, {key_out, busy, done});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        hold_len = 16'd10; press_req = 1'b1;
        tick();
        press_req = 1'b0;
        repeat (14) tick();
        n_checks++;
        if ({key_out, busy, done} !== 3'b010) begin
            n_errors++;
            $display("FAIL reset_mid_pre: got %b want 010", {key_out, busy, done});
        end
        #3 rst_n = 1'b0;
        #2;
        n_checks++;
        if ({key_out, busy, done} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset_mid_async: got %b want 100", {key_out, busy, done});
        end
        tick();
        rst_n = 1'b1;
        tick();
        hold_len = 16'd10; press_req = 1'b1;
        tick();
        press_req = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            n_checks++;
            if ({key_out, busy, done} !== exp_vec(k)) begin
                n_errors++;
                $display("FAIL reset_mid_restart k=%0d: got %b want %b", k,
                         {key_out, busy, done}, exp_vec(k));
            end
            tick();
        end
    endtask

`ifdef KEY_BOUNCE_GEN_LFSR_EN
    logic deb;
    int   deb_cnt;
    int   deb_presses;

    // Reference debouncer, CNT_MAX=10: output follows a level stable for 10 cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= 1'b1; deb_cnt <= 0; deb_presses <= 0;
        end else if (key_out !== deb) begin
            if (deb_cnt == 9) begin
                deb <= key_out; deb_cnt <= 0;
                if (key_out === 1'b0) deb_presses <= deb_presses + 1;
            end else begin
                deb_cnt <= deb_cnt + 1;
            end
        end else begin
            deb_cnt <= 0;
        end
    end

    task automatic test_lfsr();
        int   runs [0:7];
        int   nrun;
        int   first_w;
        int   start_presses;
        logic prev;
        logic varied;
        varied = 1'b0; first_w = -1;
        for (int s = 0; s < 20; s++) begin
            start_presses = deb_presses;
            hold_len = 16'd40; press_req = 1'b1;
            tick();
            press_req = 1'b0;
            prev = 1'b0; nrun = 0;
            for (int i = 0; i < 8; i++) runs[i] = 0;
            for (int k = 0; k < 200 && done !== 1'b1; k++) begin
                if (key_out !== prev) begin
                    if (nrun < 7) nrun++;
                    prev = key_out;
                end
                runs[nrun]++;
                tick();
            end
            n_checks++;
            if (done !== 1'b1 || nrun != 6) begin
                n_errors++;
                $display("FAIL lfsr_seq%0d_shape: done=%b runs=%0d want done=1 runs=6", s, done, nrun);
            end
            for (int i = 0; i <= 6; i++) begin
                if (i != 2) begin
                    n_checks++;
                    if (runs[i] < 1 || runs[i] > 8) begin
                        n_errors++;
                        $display("FAIL lfsr_seq%0d_width%0d: got %0d want 1..8", s, i, runs[i]);
                    end
                    if (first_w < 0) first_w = runs[i];
                    else if (runs[i] != first_w) varied = 1'b1;
                end
            end
            n_checks++;
            if (runs[2] < 42 || runs[2] > 56) begin
                n_errors++;
                $display("FAIL lfsr_seq%0d_hold_run: got %0d want 42..56", s, runs[2]);
            end
            repeat (12) tick();
            n_checks++;
            if (deb_presses - start_presses != 1) begin
                n_errors++;
                $display("FAIL lfsr_seq%0d_debounced: got %0d presses want 1", s,
                         deb_presses - start_presses);
            end
        end
        n_checks++;
        if (!varied) begin
            n_errors++;
            $display("FAIL lfsr_varied: got all widths %0d want differing widths", first_w);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_hold();
`ifdef KEY_BOUNCE_GEN_LFSR_EN
        test_lfsr();
`else
        test_waveform();
        test_repress();
        test_abort();
        test_reset_mid();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
